// File: rtl/div_seq_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
//   signed_div_i : 1 = signed divide (DIV), 0 = unsigned (DIVU)
//   opdata1_i    : dividend (rs)
//   opdata2_i    : divisor (rt)
//   start_i      : request, held by execute until ready_o has been seen
//   annul_i      : abort the operation in flight (pipeline flush)
//   result_o     : {remainder, quotient} for the HI/LO write
//   ready_o      : result_o valid
//   stallreq_o   : pipeline hold request while the divide is outstanding
// master = execute stage, slave = divider.
interface div_seq_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic                  stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, one quotient bit per
// clock. Operands are reduced to magnitudes on acceptance and the signs are
// reapplied after the last iteration.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : div_seq_if slave modport (request, operands, result, handshake)
module div_seq #(
    parameter int unsigned DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   dividend;   // shifts out dividend bits, shifts in quotient bits
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   rem;
    logic                sign_a;
    logic                sign_b;
    logic                is_signed;
    logic [2*DATA_W-1:0] result;
    logic                ready;

    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W:0]     shifted;
    logic [DATA_W+1:0]   trial;
    logic                trial_ok;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    always_comb begin
        abs_a = bus.opdata1_i;
        abs_b = bus.opdata2_i;
        if (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) abs_a = '0 - bus.opdata1_i;
        if (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) abs_b = '0 - bus.opdata2_i;

        shifted  = {rem, dividend[DATA_W-1]};
        trial    = {1'b0, shifted} - {2'b00, divisor};
        // Non-negative trial has both top bits clear (shifted < 2*divisor).
        trial_ok = (trial[DATA_W+1:DATA_W] == 2'b00);

        quot_fix = dividend;
        rem_fix  = rem;
        if (is_signed && (sign_a ^ sign_b)) quot_fix = '0 - dividend;
        if (is_signed && sign_a)            rem_fix  = '0 - rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FREE;
            cnt       <= '0;
            dividend  <= '0;
            divisor   <= '0;
            rem       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_signed <= 1'b0;
            result    <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                FREE: begin
                    ready  <= 1'b0;
                    result <= '0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            state <= BYZERO;
                        end else begin
                            state     <= ON;
                            dividend  <= abs_a;
                            divisor   <= abs_b;
                            rem       <= '0;
                            cnt       <= '0;
                            sign_a    <= bus.opdata1_i[DATA_W-1];
                            sign_b    <= bus.opdata2_i[DATA_W-1];
                            is_signed <= bus.signed_div_i;
                        end
                    end
                end
                BYZERO: begin
                    state  <= END;
                    result <= '0;
                    ready  <= 1'b1;
                end
                ON: begin
                    if (bus.annul_i) begin
                        state <= FREE;
                        cnt   <= '0;
                    end else if (cnt != LAST) begin
                        rem      <= trial_ok ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
                        dividend <= {dividend[DATA_W-2:0], trial_ok};
                        cnt      <= cnt + CNT_W'(1);
                    end else begin
                        result <= {rem_fix, quot_fix};
                        ready  <= 1'b1;
                        state  <= END;
                    end
                end
                END: begin
                    if (!bus.start_i) begin
                        state  <= FREE;
                        ready  <= 1'b0;
                        result <= '0;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

    assign bus.result_o   = result;
    assign bus.ready_o    = ready;
    assign bus.stallreq_o = bus.start_i & ~bus.annul_i & ~ready;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq. Inputs are driven and outputs
// sampled on the falling clock edge; all expected values are hand-computed.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_seq_if #(.DATA_W(32)) bus ();

    div_seq #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for ready, check latency/stall/result, optionally
    // hold start (with annul asserted, which must not matter in END), then drop.
    task automatic do_div(input string tag, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_lat,
                          input int hold_extra);
        int edges;
        int stall_bad;
        edges     = 0;
        stall_bad = 0;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        #1;
        while (bus.ready_o !== 1'b1 && edges < 100) begin
            if (bus.stallreq_o !== 1'b1) stall_bad++;
            @(negedge clk);
            edges++;
        end
        check({tag, "/latency"}, 64'(edges), 64'(exp_lat));
        check({tag, "/stall_wait"}, 64'(stall_bad), 64'd0);
        check({tag, "/result"}, bus.result_o, exp);
        check({tag, "/stall_ready"}, 64'(bus.stallreq_o), 64'd0);
        for (int i = 0; i < hold_extra; i++) begin
            bus.annul_i = 1'b1;
            @(negedge clk);
            check({tag, "/hold_ready"}, 64'(bus.ready_o), 64'd1);
            check({tag, "/hold_result"}, bus.result_o, exp);
        end
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        check({tag, "/drop_ready"}, 64'(bus.ready_o), 64'd0);
        check({tag, "/drop_result"}, bus.result_o, 64'd0);
    endtask

    initial begin
        int ready_seen;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        check("reset/ready", 64'(bus.ready_o), 64'd0);
        check("reset/result", bus.result_o, 64'd0);
        check("reset/stall", 64'(bus.stallreq_o), 64'd0);
        rst = 1'b0;

        do_div("divu_100_7",  1'b0, 32'd100,        32'd7,          {32'h0000_0002, 32'h0000_000E}, 34, 0);
        do_div("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0);
        do_div("div_7_m2",    1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  {32'h0000_0001, 32'hFFFF_FFFD}, 34, 0);
        do_div("div_m8_m3",   1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  {32'hFFFF_FFFE, 32'h0000_0002}, 34, 0);
        do_div("div_5_0",     1'b1, 32'd5,          32'd0,          64'd0,                          2,  0);

        // Annul mid-operation: back to FREE, no result.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'hFFFF_FFFF;
        bus.opdata2_i    = 32'd1;
        bus.start_i      = 1'b1;
        repeat (11) @(negedge clk);
        check("annul/cnt_before", 64'(dut.cnt), 64'd10);
        bus.annul_i = 1'b1;
        #1;
        check("annul/stall", 64'(bus.stallreq_o), 64'd0);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        check("annul/cnt_after", 64'(dut.cnt), 64'd0);
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready_o === 1'b1) ready_seen++;
        end
        check("annul/ready_never", 64'(ready_seen), 64'd0);
        do_div("divu_9_3",    1'b0, 32'd9,          32'd3,          {32'd0, 32'd3},                 34, 0);

        do_div("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0000_0000, 32'h8000_0000}, 34, 5);
        do_div("divu_max_1",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  {32'd0, 32'd1},                 34, 0);
        do_div("divu_big",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'd0},         34, 0);
        do_div("divu_f_16",   1'b0, 32'hFFFF_FFFF,  32'h0000_0010,  {32'h0000_000F, 32'h0FFF_FFFF}, 34, 0);

        // Start together with annul in FREE: must stay idle.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd9;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b1;
        #1;
        check("start_annul/stall", 64'(bus.stallreq_o), 64'd0);
        repeat (3) @(negedge clk);
        check("start_annul/ready", 64'(bus.ready_o), 64'd0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        do_div("after_sa",    1'b0, 32'd9,          32'd3,          {32'd0, 32'd3},                 34, 0);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1001;
        bus.opdata2_i    = 32'd10;
        bus.start_i      = 1'b1;
        repeat (16) @(negedge clk);
        check("midrst/cnt_before", 64'(dut.cnt), 64'd15);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("midrst/cnt", 64'(dut.cnt), 64'd0);
        check("midrst/ready", 64'(bus.ready_o), 64'd0);
        check("midrst/result", bus.result_o, 64'd0);
        rst = 1'b0;
        do_div("after_rst",   1'b0, 32'd1001,       32'd10,         {32'd1, 32'd100},               34, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
